// File: rtl/vga_pixel_sink.sv
// 160x120 3-bit framebuffer with a post-reset clear and a 640x480@60 VGA scan-out.
// Each framebuffer pixel is drawn as a 4x4 block; pins lag the h/v counters by two pixel ticks.
module vga_pixel_sink #(
    parameter int         FB_W       = 160,
    parameter int         FB_H       = 120,
    parameter logic [2:0] BACKGROUND = 3'b111,
    parameter int         CLK_DIV    = 2,
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic       ready,
    output logic       frame_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_pix_en
);
    localparam int DEPTH  = FB_W * FB_H;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);
    localparam logic [7:0]        X_LIM    = 8'(FB_W);
    localparam logic [6:0]        Y_LIM    = 7'(FB_H);
    localparam logic [9:0]        H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]        HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]        HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]        H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]        VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]        VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]        V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [2:0]          w_wdata;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_plot_addr;

    logic [2:0]          r_mem [DEPTH];
    logic [2:0]          r_rd_data;
    logic [ADDR_W-1:0]   w_raddr;

    logic [DIV_W-1:0]    r_div;
    logic                w_pix_en;
    logic [9:0]          r_h;
    logic [9:0]          r_v;
    logic                w_active;
    logic                w_hs_raw;
    logic                w_vs_raw;

    logic                r_act_d1;
    logic                r_hs_d1;
    logic                r_vs_d1;
    logic [2:0]          r_rgb;
    logic                r_hs;
    logic                r_vs;
    logic                r_blank_n;

    assign w_in_range  = (x < X_LIM) && (y < Y_LIM);
    assign w_plot_addr = ADDR_W'(y) * FB_W_A + ADDR_W'(x);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = r_clr_addr;
        w_wdata     = BACKGROUND;
        if (r_state == S_CLEAR) begin
            w_we = 1'b1;
            if (r_clr_addr == CLR_LAST) begin
                w_state_nxt = S_RUN;
            end
        end else begin
            w_we    = plot && w_in_range;
            w_waddr = w_plot_addr;
            w_wdata = colour;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // Simple dual-port RAM: a same-edge read of the written address returns the old word.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (w_pix_en) begin
            r_rd_data <= r_mem[w_raddr];
        end
    end

    assign w_pix_en = (r_div == DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_pix_en ? '0 : r_div + 1'b1;
            if (w_pix_en) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_raw = !((r_h >= HS_BEG) && (r_h < HS_END));
    assign w_vs_raw = !((r_v >= VS_BEG) && (r_v < VS_END));
    // Blanking lines would index past the buffer, so they read address 0 and are masked later.
    assign w_raddr  = w_active ? (ADDR_W'(r_v[9:2]) * FB_W_A + ADDR_W'(r_h[9:2])) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_act_d1  <= 1'b0;
            r_hs_d1   <= 1'b1;
            r_vs_d1   <= 1'b1;
            r_rgb     <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else if (w_pix_en) begin
            r_act_d1  <= w_active;
            r_hs_d1   <= w_hs_raw;
            r_vs_d1   <= w_vs_raw;
            r_rgb     <= r_act_d1 ? r_rd_data : '0;
            r_hs      <= r_hs_d1;
            r_vs      <= r_vs_d1;
            r_blank_n <= r_act_d1;
        end
    end

    assign ready       = (r_state == S_RUN);
    assign frame_start = w_pix_en && (r_h == '0) && (r_v == '0);
    assign vga_pix_en  = w_pix_en;
    assign vga_r       = {8{r_rgb[2]}};
    assign vga_g       = {8{r_rgb[1]}};
    assign vga_b       = {8{r_rgb[0]}};
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: a full-size instance for clear length and line timing,
// and a shrunken instance (8x6 buffer, 48x31 raster) for whole-frame image and sync checks.
module tb_vga_pixel_sink;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Full-size instance
    logic       rst_d = 1'b0, d_plot = 1'b0;
    logic [7:0] d_x = '0;
    logic [6:0] d_y = '0;
    logic [2:0] d_col = '0;
    logic       d_ready, d_fs, d_hs, d_vs, d_bl, d_pe;
    logic [7:0] d_r, d_g, d_b;

    vga_pixel_sink u_big (
        .clock(clk), .reset(rst_d), .plot(d_plot), .x(d_x), .y(d_y), .colour(d_col),
        .ready(d_ready), .frame_start(d_fs), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_bl), .vga_pix_en(d_pe)
    );

    // Shrunken instance: 8x6 buffer, 32x24 active, 48 ticks/line, 31 lines/frame
    logic       rst_s = 1'b0, s_plot = 1'b0;
    logic [7:0] s_x = '0;
    logic [6:0] s_y = '0;
    logic [2:0] s_col = '0;
    logic       s_ready, s_fs, s_hs, s_vs, s_bl, s_pe;
    logic [7:0] s_r, s_g, s_b;

    vga_pixel_sink #(
        .FB_W(8), .FB_H(6),
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clock(clk), .reset(rst_s), .plot(s_plot), .x(s_x), .y(s_y), .colour(s_col),
        .ready(s_ready), .frame_start(s_fs), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_bl), .vga_pix_en(s_pe)
    );

    logic [2:0] exp_fb [48];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_big();
        int n;
        int k;
        int ready_at;
        int hs_first;
        int hs_cnt;
        int bl_cnt;
        @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(d_ready), 0);
        check("rst_hs", 32'(d_hs), 1);
        check("rst_vs", 32'(d_vs), 1);
        check("rst_blank", 32'(d_bl), 0);
        check("rst_rgb", 32'({d_r, d_g, d_b}), 0);
        check("rst_fs", 32'(d_fs), 0);
        check("rst_pix_en", 32'(d_pe), 0);
        rst_d  = 1'b0;
        d_plot = 1'b1; d_x = 8'd5; d_y = 7'd5; d_col = 3'b100;
        n = 0; k = -1; ready_at = 0; hs_first = -1; hs_cnt = 0; bl_cnt = 0;
        while (k < 16022 && n < 40000) begin
            @(negedge clk);
            n++;
            if (n == 1) check("fs_after_rst", 32'(d_fs), 1);
            if (n == 2) check("fs_one_clk", 32'(d_fs), 0);
            if (d_ready && ready_at == 0) begin
                ready_at = n;
                d_plot   = 1'b0;
            end
            if (d_pe) begin
                k++;
                if (k < 800) begin
                    if (!d_hs) begin
                        hs_cnt++;
                        if (hs_first < 0) hs_first = k;
                    end
                    if (d_bl) bl_cnt++;
                end
                if (k == 700) check("porch_rgb", 32'({d_r, d_g, d_b}), 0);
                if (k == 16022) check("px_5_5_white", 32'({d_r, d_g, d_b}), 32'hFFFFFF);
            end
        end
        check("big_reach", k, 16022);
        check("clear_len", ready_at, 19200);
        check("hs_first_tick", hs_first, 658);
        check("hs_width", hs_cnt, 96);
        check("blank_line", bl_cnt, 640);

        // Reset while running, mid-line
        rst_d = 1'b1;
        @(negedge clk);
        check("run_rst_ready", 32'(d_ready), 0);
        check("run_rst_blank", 32'(d_bl), 0);
        rst_d = 1'b0;
        for (int i = 1; i <= 10000; i++) begin
            @(negedge clk);
            if (i == 1) check("run_rst_fs", 32'(d_fs), 1);
        end
        check("midclear_ready", 32'(d_ready), 0);

        // Reset again with the clear at address 10000
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        n = 0;
        while (!d_ready && n < 25000) begin
            @(negedge clk);
            n++;
            if (n == 1) check("midclear_fs", 32'(d_fs), 1);
        end
        check("midclear_len", n, 19200);
    endtask

    task automatic s_write(input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        s_plot = 1'b1; s_x = xx; s_y = yy; s_col = cc;
        @(negedge clk);
        s_plot = 1'b0;
    endtask

    task automatic s_next_tick();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!s_pe && g < 10);
        if (!s_pe) check("s_tick_timeout", 0, 1);
    endtask

    task automatic s_wait_fs(input string tag);
        int g = 0;
        while (!s_fs && g < 4000) begin
            @(negedge clk);
            g++;
        end
        check(tag, 32'(s_fs), 1);
    endtask

    // Entered on the frame_start clock; returns on the next frame_start clock.
    task automatic scan_frame(input string tag);
        int k = 0;
        int g = 0;
        int idx, hh, vv, pix_bad, hs_lo, vs_lo, bl_hi, hs_first;
        logic eb;
        logic [2:0] ec;
        pix_bad = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0; hs_first = -1;
        do begin
            idx = (k + 1486) % 1488;
            hh  = idx % 48;
            vv  = idx / 48;
            eb  = (hh < 32) && (vv < 24);
            ec  = eb ? exp_fb[(vv / 4) * 8 + hh / 4] : 3'b000;
            if ({s_r, s_g, s_b} !== {{8{ec[2]}}, {8{ec[1]}}, {8{ec[0]}}} || s_bl !== eb) pix_bad++;
            if (!s_hs) begin
                hs_lo++;
                if (hs_first < 0) hs_first = k;
            end
            if (!s_vs) vs_lo++;
            if (s_bl) bl_hi++;
            do begin
                @(negedge clk);
                g++;
            end while (!s_pe && g < 4000);
            k++;
        end while (!s_fs && g < 4000);
        check({tag, "_period"}, k, 1488);
        check({tag, "_image"}, pix_bad, 0);
        check({tag, "_hs_first"}, hs_first, 38);
        check({tag, "_hs_ticks"}, hs_lo, 186);
        check({tag, "_vs_ticks"}, vs_lo, 96);
        check({tag, "_active_ticks"}, bl_hi, 768);
    endtask

    task automatic run_small();
        int n;
        foreach (exp_fb[i]) exp_fb[i] = 3'b111;
        @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s_clear_len", n, 48);

        s_write(8'd0, 7'd0, 3'b001);
        s_write(8'd7, 7'd5, 3'b100);
        s_write(8'd8, 7'd0, 3'b000);
        s_write(8'd8, 7'd2, 3'b000);
        s_write(8'd0, 7'd6, 3'b000);
        exp_fb[0]  = 3'b001;
        exp_fb[47] = 3'b100;

        s_wait_fs("s_fs_seen1");
        scan_frame("f1");

        // Write (0,0) on the very edge that reads it for the new frame
        s_plot = 1'b1; s_x = 8'd0; s_y = 7'd0; s_col = 3'b010;
        @(negedge clk);
        s_plot = 1'b0;
        s_next_tick();
        s_next_tick();
        check("coll_old", 32'({s_r, s_g, s_b}), 32'h0000FF);
        s_next_tick();
        check("coll_new", 32'({s_r, s_g, s_b}), 32'h00FF00);
        exp_fb[0] = 3'b010;

        s_wait_fs("s_fs_seen2");
        scan_frame("f2");
    endtask

    initial begin
        fork
            run_big();
            run_small();
        join
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
